// File: rtl/conv_channel_in_accum_align_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_channel_in_accum_align_pkg
// Description : Shared width and saturation helpers for the channel-in
//               accumulate / output-align stage.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package conv_channel_in_accum_align_pkg;

    // Counter/pointer width for a range of n values; never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic longint sat_max(input int data_width);
        return (longint'(1) <<< (data_width - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int data_width);
        return -(longint'(1) <<< (data_width - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_channel_in_accum_align_fifo.sv
`default_nettype none
// ============================================================================
// Module      : conv_align_fifo
// Description : Show-ahead output FIFO with occupancy count, programmable
//               start level, end-of-frame flush and sticky overflow flag.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module conv_align_fifo
    import conv_channel_in_accum_align_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 256,
    parameter int START_LEVEL = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  flush,
    input  logic                  ready_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  overflow_err
);
    localparam int FIFO_PTR_W = cnt_w(FIFO_DEPTH);
    localparam int CNT_W      = FIFO_PTR_W + 1;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]      r_count, w_count_next;
    logic                  r_armed, r_flushing, r_overflow;
    logic                  w_empty, w_full, w_pop, w_push_ok;

    function automatic logic [FIFO_PTR_W-1:0] next_ptr(input logic [FIFO_PTR_W-1:0] p);
        return (p == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + FIFO_PTR_W'(1);
    endfunction

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
    assign valid_out    = r_armed & ~w_empty;
    assign w_pop        = valid_out & ready_in;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push_ok    = push & (~w_full | w_pop);
    assign pxl_out      = valid_out ? r_mem[r_rd_ptr] : '0;
    assign overflow_err = r_overflow;

    always_comb begin
        w_count_next = r_count;
        if (w_push_ok && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push_ok && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_armed    <= 1'b0;
            r_flushing <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_count <= w_count_next;
            if (w_push_ok) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            // Flush releases a short tail; once it has drained, wait for the start level again.
            if (flush) begin
                r_armed    <= 1'b1;
                r_flushing <= 1'b1;
            end else if (r_flushing && (w_count_next == '0)) begin
                r_armed    <= 1'b0;
                r_flushing <= 1'b0;
            end else if (w_count_next >= CNT_W'(START_LEVEL)) begin
                r_armed <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_channel_in_accum_align.sv
`default_nettype none
// ============================================================================
// Module      : conv_channel_in_accum_align
// Description : Accumulates per-pixel partial sums over the input channels,
//               adds bias, rescales, saturates, applies optional ReLU and
//               hands results downstream through an alignment FIFO.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module conv_channel_in_accum_align
    import conv_channel_in_accum_align_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int ACC_WIDTH       = 32,
    parameter int IMAGE_SIZE      = 256,
    parameter int CHANNEL_NUM_IN  = 256,
    parameter int CHANNEL_NUM_OUT = 256,
    parameter int SHIFT           = 0,
    parameter int FIFO_DEPTH      = 256,
    parameter int START_LEVEL     = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    input  logic [DATA_WIDTH-1:0] bias_in,
    input  logic                  relu_en,
    input  logic                  ready_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done,
    output logic                  overflow_err
);
    localparam int PIX_CNT_W = cnt_w(IMAGE_SIZE);
    localparam int CH_CNT_W  = cnt_w(CHANNEL_NUM_IN);
    localparam int OCH_CNT_W = cnt_w(CHANNEL_NUM_OUT);
    localparam int OUT_CNT_W = cnt_w(IMAGE_SIZE * CHANNEL_NUM_OUT);
    localparam logic signed [ACC_WIDTH-1:0] MAX_VAL = ACC_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] MIN_VAL = ACC_WIDTH'(sat_min(DATA_WIDTH));

    logic [PIX_CNT_W-1:0]         r_pix_cnt, r_s1_pix;
    logic [CH_CNT_W-1:0]          r_ch_cnt;
    logic [OCH_CNT_W-1:0]         r_och_cnt;
    logic [OUT_CNT_W-1:0]         r_out_cnt;
    logic signed [DATA_WIDTH-1:0] r_bias, r_s1_pxl;
    logic signed [ACC_WIDTH-1:0]  r_acc_ram [IMAGE_SIZE];
    logic signed [ACC_WIDTH-1:0]  r_rd_data;
    logic                         r_s1_valid, r_s1_first, r_s1_last, r_s1_frame_last;
    logic                         r_frame_done;
    logic                         w_last_pix, w_last_ch, w_last_och, w_push, w_flush, w_xfer;
    logic signed [ACC_WIDTH-1:0]  w_x, w_sum, w_shifted;
    logic [DATA_WIDTH-1:0]        w_result;

    assign w_last_pix = (r_pix_cnt == PIX_CNT_W'(IMAGE_SIZE - 1));
    assign w_last_ch  = (r_ch_cnt  == CH_CNT_W'(CHANNEL_NUM_IN - 1));
    assign w_last_och = (r_och_cnt == OCH_CNT_W'(CHANNEL_NUM_OUT - 1));

    // Stage 1: frame counters, bias latch, input register and RAM read issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_cnt       <= '0;
            r_ch_cnt        <= '0;
            r_och_cnt       <= '0;
            r_bias          <= '0;
            r_s1_valid      <= 1'b0;
            r_s1_pxl        <= '0;
            r_s1_pix        <= '0;
            r_s1_first      <= 1'b0;
            r_s1_last       <= 1'b0;
            r_s1_frame_last <= 1'b0;
        end else begin
            r_s1_valid <= valid_in;
            if (valid_in) begin
                r_s1_pxl        <= pxl_in;
                r_s1_pix        <= r_pix_cnt;
                r_s1_first      <= (r_ch_cnt == '0);
                r_s1_last       <= w_last_ch;
                r_s1_frame_last <= w_last_pix & w_last_ch & w_last_och;
                if ((r_pix_cnt == '0) && (r_ch_cnt == '0)) begin
                    r_bias <= bias_in;
                end
                if (w_last_pix) begin
                    r_pix_cnt <= '0;
                    if (w_last_ch) begin
                        r_ch_cnt  <= '0;
                        r_och_cnt <= w_last_och ? '0 : r_och_cnt + OCH_CNT_W'(1);
                    end else begin
                        r_ch_cnt <= r_ch_cnt + CH_CNT_W'(1);
                    end
                end else begin
                    r_pix_cnt <= r_pix_cnt + PIX_CNT_W'(1);
                end
            end
        end
    end

    // Stage 2: channel 0 seeds the accumulator with the bias; the last channel only reads.
    assign w_x       = ACC_WIDTH'(r_s1_pxl);
    assign w_sum     = r_s1_first ? (ACC_WIDTH'(r_bias) + w_x) : (r_rd_data + w_x);
    assign w_shifted = w_sum >>> SHIFT;
    assign w_push    = r_s1_valid & r_s1_last;
    assign w_flush   = w_push & r_s1_frame_last;

    always_ff @(posedge clk) begin
        if (valid_in) begin
            r_rd_data <= r_acc_ram[r_pix_cnt];
        end
        if (r_s1_valid && !r_s1_last) begin
            r_acc_ram[r_s1_pix] <= w_sum;
        end
    end

    always_comb begin
        w_result = w_shifted[DATA_WIDTH-1:0];
        if (w_shifted > MAX_VAL) begin
            w_result = MAX_VAL[DATA_WIDTH-1:0];
        end else if (w_shifted < MIN_VAL) begin
            w_result = MIN_VAL[DATA_WIDTH-1:0];
        end
        if (relu_en && w_result[DATA_WIDTH-1]) begin
            w_result = '0;
        end
    end

    conv_align_fifo #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .START_LEVEL (START_LEVEL)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (w_push),
        .push_data    (w_result),
        .flush        (w_flush),
        .ready_in     (ready_in),
        .pxl_out      (pxl_out),
        .valid_out    (valid_out),
        .overflow_err (overflow_err)
    );

    assign w_xfer     = valid_out & ready_in;
    assign frame_done = r_frame_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_cnt    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_xfer && (r_out_cnt == OUT_CNT_W'(IMAGE_SIZE * CHANNEL_NUM_OUT - 1));
            if (w_xfer) begin
                r_out_cnt <= (r_out_cnt == OUT_CNT_W'(IMAGE_SIZE * CHANNEL_NUM_OUT - 1))
                             ? '0 : r_out_cnt + OUT_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_channel_in_accum_align.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_channel_in_accum_align
// Description : Directed self-checking bench; four configurations share one
//               stimulus stream, each test inspects the relevant instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_channel_in_accum_align;
    localparam int DW = 16;
    localparam int A  = 0;  // IMAGE 4, CH_IN 3, CH_OUT 2, DEPTH 8, START 8
    localparam int S  = 1;  // as A with SHIFT 2
    localparam int O  = 2;  // as A with DEPTH 4, START 4
    localparam int F  = 3;  // IMAGE 2, CH_OUT 1

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          valid_in = 1'b0;
    logic [DW-1:0] pxl_in = '0;
    logic [DW-1:0] bias_in = '0;
    logic          relu_en = 1'b0;
    logic          ready_in = 1'b1;
    logic [DW-1:0] d_pxl [4];
    logic          d_valid [4];
    logic          d_fd [4];
    logic          d_ovf [4];

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int last_beat_cyc = 0;
    int q [4][$];
    int first_valid [4];
    int last_xfer [4];
    int fd_cnt [4];
    int fd_cyc [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_channel_in_accum_align #(.IMAGE_SIZE(4), .CHANNEL_NUM_IN(3), .CHANNEL_NUM_OUT(2),
        .SHIFT(0), .FIFO_DEPTH(8), .START_LEVEL(8)) dut_a (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in), .bias_in(bias_in),
        .relu_en(relu_en), .ready_in(ready_in), .pxl_out(d_pxl[A]), .valid_out(d_valid[A]),
        .frame_done(d_fd[A]), .overflow_err(d_ovf[A]));

    conv_channel_in_accum_align #(.IMAGE_SIZE(4), .CHANNEL_NUM_IN(3), .CHANNEL_NUM_OUT(2),
        .SHIFT(2), .FIFO_DEPTH(8), .START_LEVEL(8)) dut_s (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in), .bias_in(bias_in),
        .relu_en(relu_en), .ready_in(ready_in), .pxl_out(d_pxl[S]), .valid_out(d_valid[S]),
        .frame_done(d_fd[S]), .overflow_err(d_ovf[S]));

    conv_channel_in_accum_align #(.IMAGE_SIZE(4), .CHANNEL_NUM_IN(3), .CHANNEL_NUM_OUT(2),
        .SHIFT(0), .FIFO_DEPTH(4), .START_LEVEL(4)) dut_o (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in), .bias_in(bias_in),
        .relu_en(relu_en), .ready_in(ready_in), .pxl_out(d_pxl[O]), .valid_out(d_valid[O]),
        .frame_done(d_fd[O]), .overflow_err(d_ovf[O]));

    conv_channel_in_accum_align #(.IMAGE_SIZE(2), .CHANNEL_NUM_IN(3), .CHANNEL_NUM_OUT(1),
        .SHIFT(0), .FIFO_DEPTH(8), .START_LEVEL(8)) dut_f (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in), .bias_in(bias_in),
        .relu_en(relu_en), .ready_in(ready_in), .pxl_out(d_pxl[F]), .valid_out(d_valid[F]),
        .frame_done(d_fd[F]), .overflow_err(d_ovf[F]));

    // Output monitor, sampled just after the falling edge.
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                if (d_valid[i] && ready_in) begin
                    q[i].push_back(int'($signed(d_pxl[i])));
                    last_xfer[i] = cyc;
                end
                if (d_valid[i] && first_valid[i] < 0) first_valid[i] = cyc;
                if (d_fd[i]) begin
                    fd_cnt[i] = fd_cnt[i] + 1;
                    fd_cyc[i] = cyc;
                end
            end
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input int n, input int exp);
        check_val({tag, "_count"}, q[idx].size(), n);
        for (int i = 0; i < n; i++)
            check_val(tag, (i < q[idx].size()) ? q[idx][i] : -99999, exp);
    endtask

    task automatic clear_log();
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            first_valid[i] = -1;
            last_xfer[i]   = -1;
            fd_cnt[i]      = 0;
            fd_cyc[i]      = -1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        valid_in = 1'b0;
        clear_log();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // n beats; pixel value = base + step*(beat mod isz); optional random idle gaps.
    task automatic drive(input int n, input int base, input int step, input int bias,
                         input int isz, input bit gappy);
        for (int k = 0; k < n; k++) begin
            if (gappy) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    valid_in = 1'b0;
                end
            end
            @(negedge clk);
            valid_in      = 1'b1;
            pxl_in        = 16'(base + step * (k % isz));
            bias_in       = 16'(bias);
            last_beat_cyc = cyc;
        end
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    initial begin
        clear_log();
        do_reset();
        @(negedge clk);
        check_val("rst_valid", int'(d_valid[A]), 0);
        check_val("rst_pxl", int'(d_pxl[A]), 0);
        check_val("rst_frame_done", int'(d_fd[A]), 0);
        check_val("rst_overflow", int'(d_ovf[A]), 0);

        // Basic accumulation: 1+1+1+5 = 8 per pixel.
        ready_in = 1'b1;
        drive(24, 1, 0, 5, 4, 1'b0);
        repeat (30) @(negedge clk);
        check_all("basic", A, 8, 8);
        check_val("basic_first_valid", first_valid[A], last_beat_cyc + 2);
        check_val("basic_fd_count", fd_cnt[A], 1);
        check_val("basic_fd_timing", fd_cyc[A], last_xfer[A] + 1);
        check_val("basic_overflow", int'(d_ovf[A]), 0);

        // ReLU: 3*(-10) + 0 = -30.
        do_reset();
        relu_en = 1'b1;
        drive(24, -10, 0, 0, 4, 1'b0);
        repeat (30) @(negedge clk);
        check_all("relu_on", A, 8, 0);
        do_reset();
        relu_en = 1'b0;
        drive(24, -10, 0, 0, 4, 1'b0);
        repeat (30) @(negedge clk);
        check_all("relu_off", A, 8, -30);

        // Saturation and shift.
        do_reset();
        drive(24, 20000, 0, 0, 4, 1'b0);
        repeat (30) @(negedge clk);
        check_all("sat_pos", A, 8, 32767);
        do_reset();
        drive(24, -20000, 0, 0, 4, 1'b0);
        repeat (30) @(negedge clk);
        check_all("sat_neg", A, 8, -32768);
        do_reset();
        drive(24, 4, 0, 4, 4, 1'b0);
        repeat (30) @(negedge clk);
        check_all("noshift", A, 8, 16);
        check_all("shift2", S, 8, 4);

        // Backpressure and overflow on the 4-deep instance: results 3,6,9,12 then drops.
        do_reset();
        ready_in = 1'b0;
        drive(24, 1, 1, 0, 4, 1'b0);
        repeat (5) @(negedge clk);
        check_val("bp_overflow", int'(d_ovf[O]), 1);
        check_val("bp_valid_held", int'(d_valid[O]), 1);
        check_val("bp_head", int'($signed(d_pxl[O])), 3);
        ready_in = 1'b1;
        repeat (20) @(negedge clk);
        check_val("bp_drain_count", q[O].size(), 4);
        for (int i = 0; i < 4; i++)
            check_val("bp_drain_order", (i < q[O].size()) ? q[O][i] : -99999, 3 * (i + 1));
        check_val("bp_overflow_sticky", int'(d_ovf[O]), 1);
        check_val("bp_valid_after", int'(d_valid[O]), 0);
        check_val("bp_no_frame_done", fd_cnt[O], 0);

        // Flush with gappy input on the 2-pixel, single output channel instance.
        do_reset();
        drive(6, 1, 0, 5, 2, 1'b1);
        repeat (20) @(negedge clk);
        check_all("flush", F, 2, 8);
        check_val("flush_first_valid", first_valid[F], last_beat_cyc + 2);
        check_val("flush_fd_count", fd_cnt[F], 1);
        check_val("flush_empty_valid", int'(d_valid[F]), 0);
        // One new result, below the start level: must stay invisible once disarmed.
        drive(5, 1, 0, 5, 2, 1'b1);
        repeat (10) @(negedge clk);
        check_val("flush_disarmed", int'(d_valid[F]), 0);
        check_val("flush_disarmed_count", q[F].size(), 2);

        // Mid-frame reset during ch1 of och0, then a clean frame: 2*3+1 = 7.
        do_reset();
        drive(6, 9, 0, 3, 4, 1'b0);
        do_reset();
        drive(24, 2, 0, 1, 4, 1'b0);
        check_val("midrst_no_early_fd", fd_cnt[A], 0);
        repeat (30) @(negedge clk);
        check_all("midrst", A, 8, 7);
        check_val("midrst_fd_count", fd_cnt[A], 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
